calc_driver: RTL and testbench
==============================

Name: calc_driver

Overview:
- Command-side initiator for the calc accumulator datapath; calc responds to button strobes, this block generates them.
- Accepts queued operation commands over a valid/ready interface and buffers them in a small FIFO.
- Replays each command onto calc's button/switch inputs with stable setup and a single fire strobe, then returns the resulting led value over a valid/ready response channel.
- Used for scripted self-test and for host-driven operation of the calculator.

Parameters:
DATA_W, 16, operand/accumulator width; must match calc OLD_SIZE
DEPTH, 4, command FIFO depth in entries; power of two, >= 2
HOLD_CYC, 2, cycles btnl/btnr/btnd/sw are held stable before the fire strobe; >= 1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command
cmd_clr  input  1  1 = clear accumulator command; cmd_op and cmd_data ignored
cmd_op  input  3  {btnl,btnr,btnd} operation select, passed to calc unmodified
cmd_data  input  DATA_W  operand driven on sw
btnl  output  1  to calc
btnr  output  1  to calc
btnd  output  1  to calc
btnc  output  1  to calc, execute strobe
btnac  output  1  to calc, clear strobe
sw  output  DATA_W  to calc operand
led  input  DATA_W  from calc, accumulator value
rsp_valid  output  1  result available
rsp_ready  input  1  result consumed
rsp_data  output  DATA_W  captured led value
busy  output  1  FSM not in IDLE or FIFO not empty

Behaviour:
- Reset (rst_n low, async): FIFO emptied, FSM to IDLE, all outputs 0 (cmd_ready 0 while rst_n low, 1 after release). Commands in flight are discarded. No btnac is issued on reset; calc accumulator is untouched.
- FIFO:
  - Entry is {clr, op, data}.
  - Push on the edge where cmd_valid && cmd_ready.
  - cmd_ready = !full, computed from registered count. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, FIRE, CAPTURE, RESP.
- IDLE:
  - btnl/btnr/btnd/sw = 0, btnc = btnac = 0.
  - If the FIFO is non-empty, pop the head into a command register and go to SETUP.
- SETUP:
  - Drives btnl/btnr/btnd = op and sw = data; clr commands drive all four as 0.
  - Stays exactly HOLD_CYC cycles, then goes to FIRE.
- FIRE:
  - One cycle, with btnc = 1 (normal) or btnac = 1 (clr); never both.
  - btnl/btnr/btnd/sw remain stable; calc updates its accumulator on the edge ending FIRE.
- CAPTURE:
  - One cycle; outputs as in SETUP, btnc = btnac = 0.
  - On the edge ending CAPTURE, rsp_data <= led; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data held stable.
  - Button outputs return to 0, sw = 0.
  - On rsp_ready, rsp_valid drops on the next edge and the FSM goes to IDLE.
  - No new command is popped while in RESP (strictly one outstanding operation).
- Latency: command pushed into an empty FIFO at edge T → popped at T+1 → rsp_valid high from edge T+HOLD_CYC+3 (T+5 at defaults). Back-to-back throughput is one command per HOLD_CYC+4 cycles plus response stall.
- rsp_ready held high continuously: rsp_valid is a one-cycle pulse per command.
- Arithmetic: none internal. Operand and result width are DATA_W, passed bit-exact. Overflow is calc's concern and is not reported.

Test Plan:
- Reset release with the FIFO empty → all button outputs 0, sw 0, cmd_ready 1, busy 0, rsp_valid 0 for 20 idle cycles.
- Driver connected to calc. Push clr, then the add op with data 0x0005, then the add op with data 0xFFFD (−3), rsp_ready=1 → rsp_data sequence 0x0000, 0x0005, 0x0002. First rsp_valid at 5 cycles after the first push.
- With rsp_ready=0, push DEPTH+2 commands back-to-back → exactly DEPTH+1 accepted (1 popped plus DEPTH queued); cmd_ready low while full. No extra btnc pulses; rsp_valid and rsp_data stable while stalled.
- Per command, monitor the strobes → btnc/btnac high for exactly one cycle. btnl/btnr/btnd/sw are constant for the HOLD_CYC cycles before, during and one cycle after the strobe. btnc and btnac are never high together.
- Assert rst_n low asynchronously mid-SETUP with 3 commands queued → outputs 0 immediately, no strobe issued. After release the FIFO is empty and busy is 0.
- Push and pop in the same cycle with the FIFO holding 1 entry → count stays 1, order preserved. Pointer wrap across 3·DEPTH commands → responses in issue order.

Source files
------------

// File: rtl/calc_driver.sv
// calc_driver: command-side initiator for the calc accumulator datapath.
// Commands {clr, op, data} are queued in a small FIFO and replayed onto
// calc's button/switch inputs: operands are set up and held, a single
// btnc/btnac strobe fires, and the resulting led value is returned on a
// valid/ready response channel. One operation is outstanding at a time.
//
// state   | meaning
// IDLE    | buttons/sw low; pop FIFO head when non-empty
// SETUP   | op/data driven and held for HOLD_CYC cycles
// FIRE    | one-cycle btnc (normal) or btnac (clear) strobe
// CAPTURE | op/data still driven; led sampled into rsp_data at exit
// RESP    | rsp_valid high until rsp_ready; no new pop
module calc_driver #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clr,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              btnl,
  output logic              btnr,
  output logic              btnd,
  output logic              btnc,
  output logic              btnac,
  output logic [DATA_W-1:0] sw,
  input  logic [DATA_W-1:0] led,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int ENT_W  = DATA_W + 4;

  typedef enum logic [2:0] {IDLE, SETUP, FIRE, CAPTURE, RESP} state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              clr_q;
  logic [HOLD_W-1:0] hold_cnt;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // push even when the FSM pops in the same cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_clr, cmd_op, cmd_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencing FSM; the button/sw output registers double as the
  // command register for the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_q     <= 1'b0;
      hold_cnt  <= '0;
      btnl      <= 1'b0;
      btnr      <= 1'b0;
      btnd      <= 1'b0;
      btnc      <= 1'b0;
      btnac     <= 1'b0;
      sw        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            clr_q    <= head[ENT_W-1];
            hold_cnt <= HOLD_W'(HOLD_CYC - 1);
            if (head[ENT_W-1]) begin
              {btnl, btnr, btnd} <= 3'b000;
              sw                 <= '0;
            end else begin
              {btnl, btnr, btnd} <= head[DATA_W +: 3];
              sw                 <= head[DATA_W-1:0];
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (hold_cnt == '0) begin
            btnc  <= !clr_q;
            btnac <= clr_q;
            state <= FIRE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        FIRE: begin
          btnc  <= 1'b0;
          btnac <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data           <= led;
          rsp_valid          <= 1'b1;
          {btnl, btnr, btnd} <= 3'b000;
          sw                 <= '0;
          state              <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: drives calc_driver against a small behavioural calc and
// scores every response against expected accumulator values.
module tb_calc_driver;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 4;
  localparam int HOLD_CYC = 2;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b011;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_clr = 1'b0;
  logic [2:0]        cmd_op = 3'b000;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              btnl, btnr, btnd, btnc, btnac;
  logic [DATA_W-1:0] sw;
  logic [DATA_W-1:0] led;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_push_cyc = 0;
  int btnc_cnt = 0;
  int btnac_cnt = 0;

  logic [DATA_W-1:0] model_acc = '0;
  logic [DATA_W-1:0] calc_acc = '0;
  logic [DATA_W-1:0] sb_q [$];

  calc_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clr(cmd_clr),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .btnl(btnl), .btnr(btnr), .btnd(btnd), .btnc(btnc), .btnac(btnac),
    .sw(sw), .led(led),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] calc_f(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return b;
    endcase
  endfunction

  // Behavioural calc: clear on btnac, execute on btnc; not tied to rst_n.
  always @(posedge clk) begin
    if (btnac)     calc_acc <= '0;
    else if (btnc) calc_acc <= calc_f({btnl, btnr, btnd}, calc_acc, sw);
  end
  assign led = calc_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outv();
    return 64'({btnl, btnr, btnd, btnc, btnac, rsp_valid, busy, cmd_ready, sw, rsp_data});
  endfunction

  localparam logic [63:0] IDLE_V  = 64'(1) << (2 * DATA_W);
  localparam logic [63:0] RESET_V = 64'(0);

  function automatic void sb_expect(input logic clr, input logic [2:0] op,
                                    input logic [DATA_W-1:0] d);
    model_acc = clr ? '0 : calc_f(op, model_acc, d);
    sb_q.push_back(model_acc);
  endfunction

  task automatic push_cmd(input logic clr, input logic [2:0] op, input logic [DATA_W-1:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_clr = clr; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 64'(cmd_ready), 64'(1));
    if (cmd_ready) sb_expect(clr, op, d);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_rsp_valid(input int bound);
    int n = 0;
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_wait", 64'(rsp_valid), 64'(1));
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb_q.size()), 64'(0));
  endtask

  // Monitor: strobe shape, operand stability around the strobe, scoreboard.
  initial begin : monitor
    logic [DATA_W+2:0] hist [HOLD_CYC];
    logic [DATA_W+2:0] v;
    logic [DATA_W+2:0] strobe_v;
    logic prev_strobe, after_pending, prev_hs, hs;
    prev_strobe = 1'b0; after_pending = 1'b0; prev_hs = 1'b0; strobe_v = '0;
    for (int i = 0; i < HOLD_CYC; i++) hist[i] = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        v = {btnl, btnr, btnd, sw};
        if (btnc || btnac) begin
          chk("strobe_excl", 64'(btnc && btnac), 64'(0));
          chk("strobe_width", 64'(prev_strobe), 64'(0));
          for (int i = 0; i < HOLD_CYC; i++) chk("pre_hold", 64'(hist[i]), 64'(v));
          strobe_v = v;
          after_pending = 1'b1;
        end else if (after_pending) begin
          chk("post_hold", 64'(v), 64'(strobe_v));
          after_pending = 1'b0;
        end
        if (btnc)  btnc_cnt++;
        if (btnac) btnac_cnt++;
        prev_strobe = btnc || btnac;
        for (int i = HOLD_CYC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        hs = rsp_valid && rsp_ready;
        if (hs) begin
          chk("rsp_pulse", 64'(prev_hs), 64'(0));
          chk("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) chk("rsp_data", 64'(rsp_data), 64'(sb_q.pop_front()));
        end
        prev_hs = hs;
      end
    end
  end

  initial begin : stim
    int accepted;
    int t0;
    int bc, bac;
    logic [DATA_W-1:0] held, acc_save;
    logic [2:0] ops [5];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR; ops[4] = OP_XOR;

    // Reset held, then 20 idle cycles after release.
    repeat (3) @(negedge clk);
    chk("in_reset", outv(), RESET_V);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", outv(), IDLE_V);
    end

    // Clear, +5, +(-3) with latency check on the first command.
    rsp_ready = 1'b1;
    push_cmd(1'b1, OP_ADD, 16'h1234);
    t0 = last_push_cyc;
    wait_rsp_valid(20);
    chk("first_latency", 64'(cyc - t0), 64'(HOLD_CYC + 3));
    push_cmd(1'b0, OP_ADD, 16'h0005);
    push_cmd(1'b0, OP_ADD, 16'hFFFD);
    wait_drain(100);
    chk("acc_after_seq", 64'(led), 64'(16'h0002));

    // Stall: offer DEPTH+2 back-to-back commands with rsp_ready low.
    @(posedge clk); #1 rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_clr = 1'b0;
      cmd_op = ops[i % 5]; cmd_data = DATA_W'(16'h0101 * (i + 1));
      if (cmd_ready) begin
        accepted++;
        sb_expect(1'b0, cmd_op, cmd_data);
      end
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("stall_accepts", 64'(accepted), 64'(DEPTH + 1));
    chk("full_not_ready", 64'(cmd_ready), 64'(0));
    wait_rsp_valid(20);
    held = rsp_data;
    bc = btnc_cnt;
    repeat (8) @(negedge clk);
    chk("stall_valid", 64'(rsp_valid), 64'(1));
    chk("stall_data", 64'(rsp_data), 64'(held));
    chk("stall_btnc", 64'(btnc_cnt), 64'(bc));
    chk("stall_ready", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_drain(300);

    // Async reset mid-SETUP with three commands queued.
    @(posedge clk); #1 rsp_ready = 1'b0;
    push_cmd(1'b0, OP_SUB, 16'h0007);
    wait_rsp_valid(20);
    acc_save = model_acc;
    push_cmd(1'b0, OP_ADD, 16'h1234);
    push_cmd(1'b0, OP_XOR, 16'h5555);
    push_cmd(1'b0, OP_OR,  16'h00F0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("setup_sw", 64'(sw), 64'(16'h1234));
    chk("setup_op", 64'({btnl, btnr, btnd}), 64'(OP_ADD));
    bc = btnc_cnt; bac = btnac_cnt;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", outv(), RESET_V);
    sb_q.delete();
    model_acc = acc_save;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_out", outv(), IDLE_V);
    chk("post_reset_btnc", 64'(btnc_cnt), 64'(bc));
    chk("post_reset_btnac", 64'(btnac_cnt), 64'(bac));
    chk("acc_untouched", 64'(led), 64'(acc_save));

    // Pointer wrap: 3*DEPTH commands, responses in issue order.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      logic c;
      c = ($urandom_range(0, 5) == 0);
      push_cmd(c, ops[$urandom_range(0, 4)], DATA_W'($urandom));
    end
    wait_drain(1000);
    chk("final_acc", 64'(led), 64'(model_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
